// File: rtl/mode_transition_guard_if.sv
// Mode-word bus between the upstream mode FSM (master) and mode_transition_guard (slave).
interface mode_transition_guard_if #(
  parameter int CNT_W = 4
);
  logic [2:0]       mode_in;
  logic             clear_fault;
  logic [1:0]       grant_mode;
  logic             fault_pulse;
  logic [CNT_W-1:0] fault_cnt;
  logic             locked;
  logic [3:0]       err_info;

  modport master (
    output mode_in, clear_fault,
    input  grant_mode, fault_pulse, fault_cnt, locked, err_info
  );

  modport slave (
    input  mode_in, clear_fault,
    output grant_mode, fault_pulse, fault_cnt, locked, err_info
  );
endinterface

// File: rtl/mode_transition_guard.sv
// Legal-transition guard for the upstream mode word; forwards legal codes, counts violations, locks.
// Optional violation log: define MODE_GUARD_ERRLOG_EN to capture err_info, otherwise it reads 0.
module mode_transition_guard #(
  parameter int FAULT_LIMIT = 3,
  parameter int CNT_W       = 4
) (
  input logic clk,
  input logic rst_n,
  mode_transition_guard_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAULT_LIMIT);

  state_t           state_p1;
  logic [1:0]       prev_code_p1;
  logic [1:0]       grant_mode_p1;
  logic             fault_pulse_p1;
  logic [CNT_W-1:0] fault_cnt_p1;
  logic             locked_p1;

  logic [1:0]       code;
  logic             viol;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Steps of exactly one in either direction, no wrap; 3->0 is covered by the code==0 rule.
  function automatic logic is_legal(input logic [2:0] m, input logic [1:0] prev);
    logic [2:0] c3;
    logic [2:0] p3;
    c3 = {1'b0, m[1:0]};
    p3 = {1'b0, prev};
    return m[2] && ((c3 == p3) || (c3 == 3'd0) || (c3 == p3 + 3'd1) || (p3 == c3 + 3'd1));
  endfunction

  assign code    = bus.mode_in[1:0];
  assign viol    = (state_p1 == TRACK) && !is_legal(bus.mode_in, prev_code_p1);
  assign cnt_inc = sat_inc(fault_cnt_p1);

  // Stage p0 -> p1: state update and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1       <= IDLE;
      prev_code_p1   <= '0;
      grant_mode_p1  <= '0;
      fault_pulse_p1 <= 1'b0;
      fault_cnt_p1   <= '0;
      locked_p1      <= 1'b0;
    end else begin
      fault_pulse_p1 <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (bus.mode_in[2]) begin
            grant_mode_p1 <= code;
            prev_code_p1  <= code;
            state_p1      <= TRACK;
          end
        end
        TRACK: begin
          if (!viol) begin
            grant_mode_p1 <= code;
            prev_code_p1  <= code;
          end else begin
            fault_pulse_p1 <= 1'b1;
            fault_cnt_p1   <= cnt_inc;
            grant_mode_p1  <= '0;
            prev_code_p1   <= '0;
            if (cnt_inc >= LIMIT) begin
              state_p1  <= LOCK;
              locked_p1 <= 1'b1;
            end else begin
              state_p1 <= FAULT;
            end
          end
        end
        FAULT: begin
          grant_mode_p1 <= '0;
          if (bus.clear_fault && (bus.mode_in == 3'b100)) begin
            prev_code_p1 <= '0;
            state_p1     <= TRACK;
          end
        end
        LOCK: begin
          grant_mode_p1 <= '0;
          locked_p1     <= 1'b1;
        end
        default: begin
          grant_mode_p1 <= '0;
          locked_p1     <= 1'b1;
          state_p1      <= LOCK;
        end
      endcase
    end
  end

`ifdef MODE_GUARD_ERRLOG_EN
  logic [3:0] err_info_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_info_p1 <= '0;
    end else if (viol) begin
      err_info_p1 <= {prev_code_p1, code};
    end
  end

  assign bus.err_info = err_info_p1;
`else
  assign bus.err_info = 4'h0;
`endif

  assign bus.grant_mode  = grant_mode_p1;
  assign bus.fault_pulse = fault_pulse_p1;
  assign bus.fault_cnt   = fault_cnt_p1;
  assign bus.locked      = locked_p1;

endmodule

// File: tb/tb_mode_transition_guard.sv
// Directed and randomized bench for mode_transition_guard against a transition-rule reference model.
module tb_mode_transition_guard;

  localparam int FAULT_LIMIT = 3;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef MODE_GUARD_ERRLOG_EN
  localparam bit ERRLOG = 1'b1;
`else
  localparam bit ERRLOG = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mode_transition_guard_if #(.CNT_W(CNT_W)) bus ();

  mode_transition_guard #(
    .FAULT_LIMIT(FAULT_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 waiting for upstream, 1 tracking, 2 faulted, 3 locked.
  int m_phase;
  int m_prev;
  int m_grant;
  int m_pulse;
  int m_cnt;
  int m_locked;
  int m_err;

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_grant = 0; m_pulse = 0;
    m_cnt = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [2:0] m, input logic clr);
    int  code;
    int  diff;
    bit  legal;
    code    = int'(m[1:0]);
    diff    = code - m_prev;
    legal   = m[2] && (code == m_prev || code == 0 || diff == 1 || diff == -1);
    m_pulse = 0;
    if (m_phase == 0) begin
      if (m[2]) begin
        m_grant = code; m_prev = code; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (legal) begin
        m_grant = code; m_prev = code;
      end else begin
        m_pulse = 1;
        m_err   = m_prev * 4 + code;
        m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_grant = 0; m_prev = 0;
        m_phase = (m_cnt >= FAULT_LIMIT) ? 3 : 2;
      end
    end else if (m_phase == 2) begin
      m_grant = 0;
      if (clr && m == 3'b100) begin
        m_phase = 1; m_prev = 0;
      end
    end else begin
      m_grant = 0;
    end
    m_locked = (m_phase == 3) ? 1 : 0;
  endtask

  task automatic drive(input logic [2:0] m, input logic clr);
    bus.mode_in     = m;
    bus.clear_fault = clr;
    @(posedge clk);
    model_step(m, clr);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.mode_in = 3'b000; bus.clear_fault = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (bus.grant_mode !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_mode); end
    checks++; if (bus.fault_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%0b exp=0", bus.fault_pulse); end
    checks++; if (bus.fault_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.fault_cnt); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", bus.locked); end
    checks++; if (bus.err_info !== 4'h0) begin errors++; $display("FAIL reset_err got=%h exp=0", bus.err_info); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b011, 1'b0);
    checks++; if (bus.grant_mode !== 2'd0 || bus.fault_pulse !== 1'b0) begin
      errors++; $display("FAIL idle_no_marker got grant=%0d pulse=%0b exp grant=0 pulse=0", bus.grant_mode, bus.fault_pulse); end
    drive(3'b100, 1'b0);
    checks++; if (bus.grant_mode !== 2'd0 || bus.fault_pulse !== 1'b0 || bus.fault_cnt !== '0) begin
      errors++; $display("FAIL idle_to_track got grant=%0d pulse=%0b cnt=%0d exp 0/0/0", bus.grant_mode, bus.fault_pulse, bus.fault_cnt); end
  endtask

  task automatic test_track_sequence();
    logic [2:0] seq [4];
    logic [1:0] exp_g [4];
    seq   = '{3'b101, 3'b110, 3'b111, 3'b100};
    exp_g = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b0);
      checks++; if (bus.grant_mode !== exp_g[i] || bus.fault_pulse !== 1'b0) begin
        errors++; $display("FAIL track_seq[%0d] got grant=%0d pulse=%0b exp grant=%0d pulse=0", i, bus.grant_mode, bus.fault_pulse, exp_g[i]); end
    end
  endtask

  task automatic test_violation();
    logic [3:0] exp_err;
    exp_err = ERRLOG ? 4'b0111 : 4'h0;
    drive(3'b101, 1'b0);
    drive(3'b111, 1'b0);
    checks++; if (bus.fault_pulse !== 1'b1) begin errors++; $display("FAIL viol_pulse got=%0b exp=1", bus.fault_pulse); end
    checks++; if (bus.fault_cnt !== 4'd1) begin errors++; $display("FAIL viol_cnt got=%0d exp=1", bus.fault_cnt); end
    checks++; if (bus.grant_mode !== 2'd0) begin errors++; $display("FAIL viol_grant got=%0d exp=0", bus.grant_mode); end
    checks++; if (bus.err_info !== exp_err) begin errors++; $display("FAIL viol_err got=%b exp=%b", bus.err_info, exp_err); end
    drive(3'b100, 1'b0);
    checks++; if (bus.fault_pulse !== 1'b0 || bus.fault_cnt !== 4'd1) begin
      errors++; $display("FAIL viol_one_cycle got pulse=%0b cnt=%0d exp pulse=0 cnt=1", bus.fault_pulse, bus.fault_cnt); end
  endtask

  task automatic test_fault_clear();
    drive(3'b110, 1'b1);
    drive(3'b101, 1'b0);
    checks++; if (bus.grant_mode !== 2'd0) begin errors++; $display("FAIL fault_bad_clear got grant=%0d exp=0", bus.grant_mode); end
    drive(3'b100, 1'b1);
    checks++; if (bus.grant_mode !== 2'd0) begin errors++; $display("FAIL fault_clear got grant=%0d exp=0", bus.grant_mode); end
    drive(3'b101, 1'b0);
    checks++; if (bus.grant_mode !== 2'd1 || bus.fault_cnt !== 4'd1) begin
      errors++; $display("FAIL after_clear got grant=%0d cnt=%0d exp grant=1 cnt=1", bus.grant_mode, bus.fault_cnt); end
  endtask

  task automatic test_lock();
    drive(3'b111, 1'b0);
    checks++; if (bus.fault_cnt !== 4'd2 || bus.locked !== 1'b0) begin
      errors++; $display("FAIL second_viol got cnt=%0d locked=%0b exp cnt=2 locked=0", bus.fault_cnt, bus.locked); end
    drive(3'b100, 1'b1);
    drive(3'b101, 1'b0);
    drive(3'b111, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.fault_pulse !== 1'b1 || bus.fault_cnt !== 4'd3) begin
      errors++; $display("FAIL lock_entry got locked=%0b pulse=%0b cnt=%0d exp 1/1/3", bus.locked, bus.fault_pulse, bus.fault_cnt); end
    drive(3'b100, 1'b1);
    drive(3'b101, 1'b0);
    checks++; if (bus.locked !== 1'b1 || bus.grant_mode !== 2'd0 || bus.fault_pulse !== 1'b0 || bus.fault_cnt !== 4'd3) begin
      errors++; $display("FAIL lock_hold got locked=%0b grant=%0d pulse=%0b cnt=%0d exp 1/0/0/3", bus.locked, bus.grant_mode, bus.fault_pulse, bus.fault_cnt); end
    apply_reset();
    checks++; if (bus.locked !== 1'b0 || bus.grant_mode !== 2'd0 || bus.fault_cnt !== '0 || bus.err_info !== 4'h0) begin
      errors++; $display("FAIL lock_reset got locked=%0b grant=%0d cnt=%0d err=%h exp all 0", bus.locked, bus.grant_mode, bus.fault_cnt, bus.err_info); end
  endtask

  task automatic test_marker_violation();
    logic [3:0] exp_err;
    exp_err = ERRLOG ? 4'b0010 : 4'h0;
    drive(3'b100, 1'b0);
    drive(3'b010, 1'b1);
    checks++; if (bus.fault_pulse !== 1'b1 || bus.fault_cnt !== 4'd1) begin
      errors++; $display("FAIL marker_viol got pulse=%0b cnt=%0d exp pulse=1 cnt=1", bus.fault_pulse, bus.fault_cnt); end
    checks++; if (bus.err_info !== exp_err) begin errors++; $display("FAIL marker_err got=%b exp=%b", bus.err_info, exp_err); end
    drive(3'b100, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.grant_mode !== 2'd0 || bus.fault_pulse !== 1'b0 || bus.fault_cnt !== '0 || bus.locked !== 1'b0 || bus.err_info !== 4'h0) begin
      errors++; $display("FAIL async_reset got grant=%0d pulse=%0b cnt=%0d locked=%0b err=%h exp all 0",
                         bus.grant_mode, bus.fault_pulse, bus.fault_cnt, bus.locked, bus.err_info); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] m;
    logic       clr;
    logic [3:0] exp_err;
    int         prev_pulse;
    prev_pulse = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 45 == 44) begin
        apply_reset();
        prev_pulse = 0;
      end
      m   = {($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3))};
      clr = ($urandom_range(0, 3) == 0);
      if (clr && $urandom_range(0, 1) == 1) m = 3'b100;
      drive(m, clr);
      exp_err = ERRLOG ? 4'(m_err) : 4'h0;
      checks++; if (bus.grant_mode !== 2'(m_grant)) begin errors++; $display("FAIL rnd_grant[%0d] got=%0d exp=%0d", i, bus.grant_mode, m_grant); end
      checks++; if (bus.fault_pulse !== 1'(m_pulse)) begin errors++; $display("FAIL rnd_pulse[%0d] got=%0b exp=%0d", i, bus.fault_pulse, m_pulse); end
      checks++; if (bus.fault_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, bus.fault_cnt, m_cnt); end
      checks++; if (bus.locked !== 1'(m_locked)) begin errors++; $display("FAIL rnd_locked[%0d] got=%0b exp=%0d", i, bus.locked, m_locked); end
      checks++; if (bus.err_info !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got=%h exp=%h", i, bus.err_info, exp_err); end
      checks++; if (prev_pulse == 1 && bus.fault_pulse === 1'b1) begin errors++; $display("FAIL rnd_double_pulse[%0d] got=1 exp=0", i); end
      prev_pulse = int'(bus.fault_pulse);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus.mode_in = 3'b000;
    bus.clear_fault = 1'b0;
    model_reset();
    test_reset();
    test_track_sequence();
    test_violation();
    test_fault_clear();
    test_lock();
    test_marker_violation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
